// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit, 8-register CPU: opcodes, ALU codes,
// sequencer states and the decoded-instruction record.
package cpu_pkg;

  localparam int DW  = 16;
  localparam int RSW = 3;
  localparam logic [RSW-1:0] PC_REG = 3'b111;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_PASSB = 3'd4;

  typedef enum logic [3:0] {
    C_ALU, C_ADDI, C_LDI, C_LD, C_ST, C_BEQ, C_JMP, C_HALT, C_NOP
  } instr_cls_e;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_BR, S_BRWB, S_WB, S_HALT
  } state_e;

  typedef struct packed {
    instr_cls_e      cls;
    logic [RSW-1:0]  rd;
    logic [RSW-1:0]  rs0;
    logic [RSW-1:0]  rs1;
    logic [DW-1:0]   imm;
    logic [2:0]      alu_op;
  } dec_t;

  function automatic logic [DW-1:0] sext6(input logic [5:0] v);
    return {{(DW-6){v[5]}}, v};
  endfunction

  function automatic logic [DW-1:0] sext9(input logic [8:0] v);
    return {{(DW-9){v[8]}}, v};
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: IR -> class, register fields,
// sign-extended immediate and ALU operation.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [DW-1:0] ir,
  output dec_t          dec
);

  always_comb begin
    dec        = '0;
    dec.cls    = C_NOP;
    dec.rd     = ir[11:9];
    dec.rs0    = ir[8:6];
    dec.rs1    = ir[5:3];
    dec.alu_op = ALU_ADD;
    unique case (ir[15:12])
      OP_ADD:  dec.cls = C_ALU;
      OP_SUB:  begin dec.cls = C_ALU; dec.alu_op = ALU_SUB; end
      OP_AND:  begin dec.cls = C_ALU; dec.alu_op = ALU_AND; end
      OP_OR:   begin dec.cls = C_ALU; dec.alu_op = ALU_OR;  end
      OP_ADDI: begin dec.cls = C_ADDI; dec.imm = sext6(ir[5:0]); end
      OP_LDI:  begin dec.cls = C_LDI; dec.imm = sext9(ir[8:0]); dec.alu_op = ALU_PASSB; end
      OP_LD:   begin dec.cls = C_LD;  dec.imm = sext6(ir[5:0]); end
      OP_ST:   begin dec.cls = C_ST;  dec.imm = sext6(ir[5:0]); end
      // The branch compare is a SUB of rs0 and rd; the target add happens in BR.
      OP_BEQ:  begin dec.cls = C_BEQ; dec.imm = sext6(ir[5:0]); dec.alu_op = ALU_SUB; end
      OP_JMP:  begin dec.cls = C_JMP; dec.imm = sext9(ir[8:0]); end
      OP_HALT: dec.cls = C_HALT;
      default: dec.cls = C_NOP;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer. Every control is registered
// on posedge so it is settled before the register file's negedge sample.
module ctrl_sequencer
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [DW-1:0]  mem_rdata,
  input  logic           mem_ack,
  input  logic           alu_zero,
  output logic           mem_req,
  output logic           mem_we,
  output logic           mem_addr_sel,
  output logic [RSW-1:0] regr0s,
  output logic [RSW-1:0] regr1s,
  output logic [RSW-1:0] regws,
  output logic           we,
  output logic           incr_pc,
  output logic [2:0]     alu_op,
  output logic           alu_bsel,
  output logic [DW-1:0]  imm,
  output logic           wb_sel,
  output logic           halted
);

  state_e        state;
  logic [DW-1:0] ir;
  logic [DW-1:0] dec_in;
  dec_t          d;
  logic          wr_ok;
  logic          use_imm;

  // Decode the incoming word while fetching so DECODE-cycle selects are ready on entry.
  assign dec_in = (state == S_FETCH) ? mem_rdata : ir;

  instr_decode u_dec (
    .ir  (dec_in),
    .dec (d)
  );

  // R0 is hardwired and R7 is only writable through the branch path.
  assign wr_ok = ((d.cls == C_ALU) || (d.cls == C_ADDI) || (d.cls == C_LDI) ||
                  (d.cls == C_LD)) && (d.rd != '0) && (d.rd != PC_REG);
  assign use_imm = (d.cls == C_ADDI) || (d.cls == C_LDI) || (d.cls == C_LD) ||
                   (d.cls == C_ST) || (d.cls == C_JMP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_FETCH;
      ir           <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr_sel <= 1'b0;
      regr0s       <= '0;
      regr1s       <= '0;
      regws        <= '0;
      we           <= 1'b0;
      incr_pc      <= 1'b0;
      alu_op       <= '0;
      alu_bsel     <= 1'b0;
      imm          <= '0;
      wb_sel       <= 1'b0;
      halted       <= 1'b0;
    end else begin
      we      <= 1'b0;
      incr_pc <= 1'b0;
      unique case (state)
        S_FETCH: begin
          if (mem_req && mem_ack) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
            regr0s  <= ((d.cls == C_BEQ) || (d.cls == C_JMP)) ? PC_REG : d.rs0;
            regr1s  <= ((d.cls == C_ST) || (d.cls == C_BEQ)) ? d.rd : d.rs1;
            imm     <= d.imm;
            state   <= S_DECODE;
          end else begin
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr_sel <= 1'b0;
            regr0s       <= PC_REG;
          end
        end
        S_DECODE: begin
          alu_op   <= d.alu_op;
          alu_bsel <= use_imm;
          if (d.cls == C_BEQ) regr0s <= d.rs0;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if ((d.cls == C_LD) || (d.cls == C_ST)) begin
            mem_req      <= 1'b1;
            mem_addr_sel <= 1'b1;
            mem_we       <= (d.cls == C_ST);
            state        <= S_MEM;
          end else if ((d.cls == C_JMP) || ((d.cls == C_BEQ) && alu_zero)) begin
            regr0s   <= PC_REG;
            alu_op   <= ALU_ADD;
            alu_bsel <= 1'b1;
            state    <= S_BR;
          end else if (d.cls == C_HALT) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr_sel <= 1'b0;
            regr0s       <= '0;
            regr1s       <= '0;
            regws        <= '0;
            alu_op       <= '0;
            alu_bsel     <= 1'b0;
            imm          <= '0;
            wb_sel       <= 1'b0;
            halted       <= 1'b1;
            state        <= S_HALT;
          end else begin
            we      <= wr_ok;
            regws   <= d.rd;
            wb_sel  <= 1'b0;
            incr_pc <= 1'b1;
            state   <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr_sel <= 1'b0;
            we           <= wr_ok;
            regws        <= d.rd;
            wb_sel       <= (d.cls == C_LD);
            incr_pc      <= 1'b1;
            state        <= S_WB;
          end
        end
        S_BR: begin
          we     <= 1'b1;
          regws  <= PC_REG;
          wb_sel <= 1'b0;
          state  <= S_BRWB;
        end
        S_BRWB, S_WB: begin
          mem_req      <= 1'b1;
          mem_addr_sel <= 1'b0;
          regr0s       <= PC_REG;
          wb_sel       <= 1'b0;
          state        <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
